peripheral_mpram_arbiter_wb: RTL and testbench
==============================================

PERIPHERAL_MPRAM_ARBITER_WB -- requirements
Module: peripheral_mpram_arbiter_wb

Interface
REQ-001 Parameter NUM_PORTS, default 2: number of Wishbone masters sharing the RAM; legal range 2..8.
REQ-002 Parameter AW, default 10: address width forwarded to the RAM (matches $clog2 of RAM DEPTH).
REQ-003 Parameter DW, default 32: data width; select width is DW/8.
REQ-004 Parameter TIMEOUT, default 255: granted-cycle watchdog limit in clocks; 0 disables the watchdog.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 wb_clk_i  in  1  sole clock, all state on rising edge.
REQ-007 wb_rst_i  in  1  synchronous active-high reset.
REQ-008 m_adr_i  in  NUM_PORTS*AW  packed master addresses, port k at [k*AW +: AW].
REQ-009 m_dat_i  in  NUM_PORTS*DW  packed master write data.
REQ-010 m_sel_i  in  NUM_PORTS*DW/8  packed byte selects.
REQ-011 m_we_i, m_cyc_i, m_stb_i  in  NUM_PORTS each  per-master write enable, cycle, strobe.
REQ-012 m_cti_i  in  NUM_PORTS*3 and m_bte_i  in  NUM_PORTS*2  per-master burst tags.
REQ-013 m_dat_o  out  DW  RAM read data, broadcast to all masters.
REQ-014 m_ack_o, m_err_o  out  NUM_PORTS each  per-master acknowledge and error.
REQ-015 s_adr_o AW, s_dat_o DW, s_sel_o DW/8, s_we_o 1, s_cyc_o 1, s_stb_o 1, s_cti_o 3, s_bte_o 2  out  forwarded to RAM slave.
REQ-016 s_dat_i  in  DW, s_ack_i  in  1, s_err_i  in  1  RAM slave response.
REQ-017 grant_o  out  NUM_PORTS  one-hot registered grant, all-zero when idle (debug/visibility).

Function
REQ-018 Request of port k = m_cyc_i[k]; m_stb_i is not used for arbitration.
REQ-019 States: IDLE (grant all-zero) and BUSY (exactly one grant bit set).
REQ-020 IDLE: at a clock edge with any request, grant the first requesting port searching from pointer p upward modulo NUM_PORTS; go BUSY; no request -> stay IDLE.
REQ-021 Grant latency: request sampled at edge t, grant_o and slave signals for that master valid from edge t (combinational mux driven by registered grant after t).
REQ-022 BUSY: grant held while granted master's m_cyc_i stays 1, independent of other requests, cti or bte (bursts never split).
REQ-023 BUSY, granted m_cyc_i = 0 at edge: p <= granted index + 1 mod NUM_PORTS; re-arbitrate per REQ-020 in the same edge from the new p (excluding no one); no request -> IDLE.
REQ-024 Slave outputs = granted master's signals; in IDLE s_cyc_o = s_stb_o = s_we_o = 0, other s_* outputs 0.
REQ-025 s_cyc_o and s_stb_o additionally forced 0 in the cycle the watchdog fires.
REQ-026 m_ack_o[k] = s_ack_i & grant_o[k]; m_err_o[k] = (s_err_i & grant_o[k]) | watchdog error pulse for k; ungranted ports see 0.
REQ-027 Watchdog: counter cleared on each grant change and each s_ack_i/s_err_i; increments each BUSY cycle with s_stb_o = 1 and no ack.
REQ-028 Counter reaching TIMEOUT: one-cycle m_err_o pulse to granted port, force release as in REQ-023; counter saturates, never wraps.
REQ-029 Master that keeps m_cyc_i high after a watchdog release is treated as a fresh requester at its round-robin position.
REQ-030 No combinational path from s_ack_i to any s_* output.

Reset
REQ-031 On wb_rst_i = 1 at an edge: state IDLE, grant_o = 0, p = 0, watchdog counter = 0.
REQ-032 During and after reset until first grant: s_cyc_o = s_stb_o = 0, m_ack_o = m_err_o = 0.
REQ-033 Reset asserted mid-transfer aborts the grant at that edge; no ack or err is delivered for the aborted access.

Verification
REQ-034 Single master: port 0 writes 0xDEADBEEF to 0x010, then reads 0x010 -> read returns 0xDEADBEEF, m_ack_o[1] never asserts.
REQ-035 Simultaneous cyc from ports 0 and 1 after reset -> port 0 granted first; on its release port 1 granted at the same edge; next contention grants port 0 again only after port 1 releases.
REQ-036 Port 1 runs 4-beat incrementing burst (cti 010, last 111) at 0x020 while port 0 requests -> all 4 beats acked to port 1 with no interleave, then port 0 granted.
REQ-037 TIMEOUT = 8, slave ack tied low, port 0 strobes -> m_err_o[0] pulses exactly 8 stalled cycles after grant, s_cyc_o drops that cycle, grant passes to pending port 1.
REQ-038 wb_rst_i pulsed for 1 cycle during a port 1 burst -> grant_o = 0 and s_cyc_o = 0 next cycle, p = 0 so port 0 wins subsequent contention.
REQ-039 Random 2-port traffic 10000 cycles vs. reference memory model -> every read matches last write, never more than one grant bit set.

Source files
------------

// File: rtl/peripheral_mpram_arbiter_wb.sv
// Round-robin Wishbone arbiter: NUM_PORTS masters share one RAM slave port.
// A master keeps the grant for as long as its CYC stays high, so bursts are
// never split. A watchdog aborts a granted master that stalls too long.
module peripheral_mpram_arbiter_wb #(
  parameter int NUM_PORTS = 2,
  parameter int AW        = 10,
  parameter int DW        = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [NUM_PORTS*AW-1:0]  m_adr_i,
  input  logic [NUM_PORTS*DW-1:0]  m_dat_i,
  input  logic [NUM_PORTS*DW/8-1:0] m_sel_i,
  input  logic [NUM_PORTS-1:0]     m_we_i,
  input  logic [NUM_PORTS-1:0]     m_cyc_i,
  input  logic [NUM_PORTS-1:0]     m_stb_i,
  input  logic [NUM_PORTS*3-1:0]   m_cti_i,
  input  logic [NUM_PORTS*2-1:0]   m_bte_i,
  output logic [DW-1:0]            m_dat_o,
  output logic [NUM_PORTS-1:0]     m_ack_o,
  output logic [NUM_PORTS-1:0]     m_err_o,
  output logic [AW-1:0]            s_adr_o,
  output logic [DW-1:0]            s_dat_o,
  output logic [DW/8-1:0]          s_sel_o,
  output logic                     s_we_o,
  output logic                     s_cyc_o,
  output logic                     s_stb_o,
  output logic [2:0]               s_cti_o,
  output logic [1:0]               s_bte_o,
  input  logic [DW-1:0]            s_dat_i,
  input  logic                     s_ack_i,
  input  logic                     s_err_i,
  output logic [NUM_PORTS-1:0]     grant_o
);

  localparam int SW = DW / 8;
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state;
  logic [NUM_PORTS-1:0] grant;
  logic [PW-1:0]        gidx;
  logic [PW-1:0]        ptr;
  logic [CW-1:0]        wd_cnt;
  logic                 wd_fire;
  logic                 rel;
  logic [PW-1:0]        base;
  logic                 found;
  logic [PW-1:0]        pick;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] idx);
    if (int'(idx) == NUM_PORTS - 1) return '0;
    return idx + PW'(1);
  endfunction

  // Watchdog fires purely from registered state, so it never depends on s_ack_i.
  assign wd_fire = (TIMEOUT != 0) && (state == BUSY) && (wd_cnt == CW'(TIMEOUT));

  // Release decision and round-robin search from the (possibly advanced) pointer.
  always_comb begin
    rel   = (state == BUSY) && (!m_cyc_i[gidx] || wd_fire);
    base  = rel ? next_ptr(gidx) : ptr;
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && m_cyc_i[(int'(base) + i) % NUM_PORTS]) begin
        found = 1'b1;
        pick  = PW'((int'(base) + i) % NUM_PORTS);
      end
    end
  end

  // Grant FSM, round-robin pointer and watchdog counter.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state  <= IDLE;
      grant  <= '0;
      gidx   <= '0;
      ptr    <= '0;
      wd_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (found) begin
            state <= BUSY;
            grant <= NUM_PORTS'(1) << pick;
            gidx  <= pick;
          end
        end
        BUSY: begin
          if (rel) begin
            ptr    <= base;
            wd_cnt <= '0;
            if (found) begin
              grant <= NUM_PORTS'(1) << pick;
              gidx  <= pick;
            end else begin
              state <= IDLE;
              grant <= '0;
            end
          end else if (s_ack_i || s_err_i) begin
            wd_cnt <= '0;
          end else if (s_stb_o && (TIMEOUT != 0) && (wd_cnt != CW'(TIMEOUT))) begin
            wd_cnt <= wd_cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  // Forward the granted master to the slave; everything zero while idle.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    if (state == BUSY) begin
      s_adr_o = m_adr_i[int'(gidx)*AW +: AW];
      s_dat_o = m_dat_i[int'(gidx)*DW +: DW];
      s_sel_o = m_sel_i[int'(gidx)*SW +: SW];
      s_we_o  = m_we_i[gidx];
      s_cyc_o = m_cyc_i[gidx] & ~wd_fire;
      s_stb_o = m_stb_i[gidx] & ~wd_fire;
      s_cti_o = m_cti_i[int'(gidx)*3 +: 3];
      s_bte_o = m_bte_i[int'(gidx)*2 +: 2];
    end
  end

  assign m_dat_o = s_dat_i;
  assign m_ack_o = grant & {NUM_PORTS{s_ack_i}};
  assign m_err_o = grant & {NUM_PORTS{s_err_i | wd_fire}};
  assign grant_o = grant;

endmodule

// File: tb/tb_peripheral_mpram_arbiter_wb.sv
// Bench for peripheral_mpram_arbiter_wb: two masters, behavioural RAM slave,
// reference memory model and a queue of expected read data.
module tb_peripheral_mpram_arbiter_wb;

  localparam int NP = 2;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int TO = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP*AW-1:0] m_adr;
  logic [NP*DW-1:0] m_dat;
  logic [NP*4-1:0]  m_sel;
  logic [NP-1:0]    m_we, m_cyc, m_stb;
  logic [NP*3-1:0]  m_cti;
  logic [NP*2-1:0]  m_bte;
  logic [DW-1:0]    m_dat_o;
  logic [NP-1:0]    m_ack_o, m_err_o, grant_o;
  logic [AW-1:0]    s_adr_o;
  logic [DW-1:0]    s_dat_o;
  logic [3:0]       s_sel_o;
  logic             s_we_o, s_cyc_o, s_stb_o;
  logic [2:0]       s_cti_o;
  logic [1:0]       s_bte_o;
  logic [DW-1:0]    s_rdat;
  logic             s_ack;
  logic             s_err;
  logic             stall;

  peripheral_mpram_arbiter_wb #(.NUM_PORTS(NP), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_cti_i(m_cti), .m_bte_i(m_bte),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_rdat), .s_ack_i(s_ack), .s_err_i(s_err), .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  assign s_err = 1'b0;

  // RAM slave: one-cycle registered ack, read-before-write, byte lanes.
  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (rst) begin
      s_ack <= 1'b0;
    end else if (s_cyc_o && s_stb_o && !s_ack && !stall) begin
      s_ack  <= 1'b1;
      s_rdat <= mem[s_adr_o];
      if (s_we_o)
        for (int b = 0; b < 4; b++)
          if (s_sel_o[b]) mem[s_adr_o][b*8 +: 8] <= s_dat_o[b*8 +: 8];
    end else begin
      s_ack <= 1'b0;
    end
  end

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "global timeout");
  end

  typedef struct {
    int          port;
    logic        we;
    logic [9:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl [10];
  logic [31:0] exp_q [$];
  logic [31:0] model [int];
  int          cmp_cnt = 0;
  int          err_cnt = 0;
  int          ack1_cnt = 0;
  int          rd_checked = 0;
  bit          done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int k, input logic cyc, input logic we, input logic [9:0] adr,
                     input logic [31:0] dat, input logic [2:0] cti);
    m_cyc[k] = cyc;
    m_stb[k] = cyc;
    m_we[k]  = we;
    m_adr[k*AW +: AW] = adr;
    m_dat[k*DW +: DW] = dat;
    m_sel[k*4 +: 4]   = 4'hF;
    m_cti[k*3 +: 3]   = cti;
    m_bte[k*2 +: 2]   = 2'b00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0;
    m_sel = '0; m_cti = '0; m_bte = '0;
    stall = 1'b0;
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  task automatic wb_xfer(input int k, input logic we, input logic [9:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rd, output logic ok);
    @(posedge clk);
    #1;
    drv(k, 1'b1, we, adr, dat, 3'b000);
    m_sel[k*4 +: 4] = sel;
    ok = 1'b0;
    rd = '0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (m_ack_o[k]) begin
        ok = 1'b1;
        rd = m_dat_o;
      end
    end
    if (!ok) check("xfer_ack_timeout", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    m_cyc[k] = 1'b0;
    m_stb[k] = 1'b0;
    m_we[k]  = 1'b0;
  endtask

  task automatic rnd_master(input int k, input int end_cyc);
    logic [31:0] rd;
    logic        ok;
    logic        we;
    logic [3:0]  sel;
    while (cycle < end_cyc) begin
      we  = 1'($urandom_range(0, 1));
      sel = (we && $urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 14)) : 4'hF;
      wb_xfer(k, we, 10'h100 + 10'($urandom_range(0, 15)), $urandom, sel, rd, ok);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
  endtask

  initial begin
    logic [31:0] rd, e;
    logic        ok;
    int          a1, interleave, got;

    tbl[0] = '{0, 1'b1, 10'h010, 32'hDEADBEEF, 4'hF, 32'h0};
    tbl[1] = '{0, 1'b0, 10'h010, 32'h0,        4'hF, 32'hDEADBEEF};
    tbl[2] = '{1, 1'b1, 10'h011, 32'h12345678, 4'hF, 32'h0};
    tbl[3] = '{1, 1'b1, 10'h011, 32'hAABBCCDD, 4'h5, 32'h0};
    tbl[4] = '{0, 1'b0, 10'h011, 32'h0,        4'hF, 32'h12BB56DD};
    tbl[5] = '{1, 1'b0, 10'h010, 32'h0,        4'hF, 32'hDEADBEEF};
    tbl[6] = '{0, 1'b1, 10'h3FF, 32'hFFFFFFFF, 4'hF, 32'h0};
    tbl[7] = '{1, 1'b0, 10'h3FF, 32'h0,        4'hF, 32'hFFFFFFFF};
    tbl[8] = '{0, 1'b1, 10'h3FF, 32'h00123456, 4'h8, 32'h0};
    tbl[9] = '{1, 1'b0, 10'h3FF, 32'h0,        4'hF, 32'h00FFFFFF};

    rst = 1'b1;
    stall = 1'b0;
    m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_cti = '0; m_bte = '0;
    m_cyc = '1; m_stb = '1;

    fork
      begin
        // reset holds everything idle even with requests present
        nxt();
        nxt();
        check("rst_grant", 32'(grant_o), 32'd0);
        check("rst_s_cyc", 32'(s_cyc_o), 32'd0);
        check("rst_s_stb", 32'(s_stb_o), 32'd0);
        check("rst_m_ack", 32'(m_ack_o), 32'd0);
        check("rst_m_err", 32'(m_err_o), 32'd0);
        m_cyc = '0; m_stb = '0;
        rst = 1'b0;
        nxt();
        check("idle_grant", 32'(grant_o), 32'd0);
        check("idle_slave_zero", 32'(|{s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o, s_bte_o}), 32'd0);

        // table of single transfers
        for (int i = 0; i < 10; i++) begin
          if (i == 0) a1 = ack1_cnt;
          if (!tbl[i].we) exp_q.push_back(tbl[i].exp);
          wb_xfer(tbl[i].port, tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, rd, ok);
          if (!tbl[i].we) begin
            e = exp_q.pop_front();
            if (ok) check($sformatf("tbl_read_%0d", i), rd, e);
          end
          if (i == 1) check("single_master_no_port1_ack", 32'(ack1_cnt - a1), 32'd0);
        end

        // contention: port 0 first, then port 1 at the release edge, no split
        do_reset();
        drv(0, 1'b1, 1'b0, 10'h010, 32'h0, 3'b000);
        drv(1, 1'b1, 1'b0, 10'h011, 32'h0, 3'b000);
        nxt();
        check("cont_first", 32'(grant_o), 32'd1);
        nxt();
        check("cont_hold", 32'(grant_o), 32'd1);
        drv(0, 1'b0, 1'b0, 10'h010, 32'h0, 3'b000);
        nxt();
        check("cont_handover", 32'(grant_o), 32'd2);
        drv(0, 1'b1, 1'b0, 10'h010, 32'h0, 3'b000);
        nxt();
        check("cont_keep_p1_a", 32'(grant_o), 32'd2);
        nxt();
        check("cont_keep_p1_b", 32'(grant_o), 32'd2);
        drv(1, 1'b0, 1'b0, 10'h011, 32'h0, 3'b000);
        nxt();
        check("cont_back_p0", 32'(grant_o), 32'd1);
        drv(0, 1'b0, 1'b0, 10'h010, 32'h0, 3'b000);
        nxt();
        nxt();
        check("cont_idle", 32'(grant_o), 32'd0);

        // 4-beat burst on port 1 while port 0 waits
        do_reset();
        drv(1, 1'b1, 1'b1, 10'h020, 32'hB0000000, 3'b010);
        nxt();
        check("burst_grant_p1", 32'(grant_o), 32'd2);
        drv(0, 1'b1, 1'b0, 10'h010, 32'h0, 3'b000);
        interleave = 0;
        for (int b = 0; b < 4; b++) begin
          got = 0;
          for (int i = 0; i < 20 && got == 0; i++) begin
            nxt();
            check("burst_grant_held", 32'(grant_o), 32'd2);
            if (m_ack_o[0]) interleave++;
            if (m_ack_o[1]) begin
              got = 1;
              check("burst_cti", 32'(s_cti_o), (b == 3) ? 32'd7 : 32'd2);
            end
          end
          check($sformatf("burst_beat_%0d_ack", b), 32'(got), 32'd1);
          if (b < 3)
            drv(1, 1'b1, 1'b1, 10'h020 + 10'(b + 1), 32'hB0000000 + 32'(b + 1),
                (b + 1 == 3) ? 3'b111 : 3'b010);
        end
        drv(1, 1'b0, 1'b0, 10'h000, 32'h0, 3'b000);
        nxt();
        check("burst_then_p0", 32'(grant_o), 32'd1);
        check("burst_no_interleave", 32'(interleave), 32'd0);
        drv(0, 1'b0, 1'b0, 10'h010, 32'h0, 3'b000);
        nxt();
        for (int b = 0; b < 4; b++) begin
          exp_q.push_back(32'hB0000000 + 32'(b));
          wb_xfer(0, 1'b0, 10'h020 + 10'(b), 32'h0, 4'hF, rd, ok);
          e = exp_q.pop_front();
          if (ok) check($sformatf("burst_readback_%0d", b), rd, e);
        end

        // watchdog: slave never acks, port 1 pending
        do_reset();
        stall = 1'b1;
        drv(0, 1'b1, 1'b0, 10'h010, 32'h0, 3'b000);
        drv(1, 1'b1, 1'b0, 10'h011, 32'h0, 3'b000);
        nxt();
        check("wd_grant_p0", 32'(grant_o), 32'd1);
        for (int i = 0; i < 8; i++) begin
          if (i > 0) nxt();
          check($sformatf("wd_no_err_%0d", i), 32'(m_err_o), 32'd0);
          check($sformatf("wd_cyc_on_%0d", i), 32'(s_cyc_o), 32'd1);
        end
        nxt();
        check("wd_err_pulse", 32'(m_err_o), 32'd1);
        check("wd_cyc_dropped", 32'(s_cyc_o), 32'd0);
        nxt();
        check("wd_pass_p1", 32'(grant_o), 32'd2);
        check("wd_err_one_cycle", 32'(m_err_o), 32'd0);
        drv(0, 1'b0, 1'b0, 10'h010, 32'h0, 3'b000);
        drv(1, 1'b0, 1'b0, 10'h011, 32'h0, 3'b000);
        nxt();
        stall = 1'b0;
        nxt();
        check("wd_idle", 32'(grant_o), 32'd0);

        // reset pulse during a port 1 burst
        do_reset();
        drv(1, 1'b1, 1'b0, 10'h030, 32'h0, 3'b010);
        nxt();
        check("rb_grant_p1", 32'(grant_o), 32'd2);
        nxt();
        nxt();
        rst = 1'b1;
        drv(0, 1'b1, 1'b0, 10'h010, 32'h0, 3'b000);
        nxt();
        check("rb_grant_cleared", 32'(grant_o), 32'd0);
        check("rb_s_cyc", 32'(s_cyc_o), 32'd0);
        check("rb_no_ack", 32'(m_ack_o), 32'd0);
        check("rb_no_err", 32'(m_err_o), 32'd0);
        rst = 1'b0;
        nxt();
        check("rb_p0_wins", 32'(grant_o), 32'd1);
        drv(0, 1'b0, 1'b0, 10'h010, 32'h0, 3'b000);
        drv(1, 1'b0, 1'b0, 10'h030, 32'h0, 3'b000);
        nxt();
        nxt();

        // random two-master traffic against the reference model
        rd_checked = 0;
        a1 = cycle + 10000;
        fork
          rnd_master(0, a1);
          rnd_master(1, a1);
        join
        check("rnd_reads_checked", 32'(rd_checked > 100), 32'd1);
        done = 1;
      end
      begin
        // monitor: one grant at most, reference memory on every acked access
        while (!done) begin
          @(negedge clk);
          if (!rst) check("grant_onehot", 32'($countones(grant_o) <= 1), 32'd1);
          if (m_ack_o[1]) ack1_cnt++;
          for (int k = 0; k < NP; k++) begin
            if (m_ack_o[k]) begin
              int          a;
              logic [31:0] w;
              logic [3:0]  s;
              a = int'(m_adr[k*AW +: AW]);
              w = m_dat[k*DW +: DW];
              s = m_sel[k*4 +: 4];
              if (m_we[k]) begin
                if (s == 4'hF) begin
                  model[a] = w;
                end else if (model.exists(a)) begin
                  for (int b = 0; b < 4; b++)
                    if (s[b]) model[a][b*8 +: 8] = w[b*8 +: 8];
                end
              end else if (model.exists(a)) begin
                rd_checked++;
                check("model_read", m_dat_o, model[a]);
              end
            end
          end
        end
      end
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
